key_pio_service_master: RTL
===========================

Name: key_pio_service_master

Overview:
- Avalon-MM initiator that services the 4-bit key input PIO (the edge-capturing, interrupt-generating slave) in hardware, so no Nios software is needed for key handling.
- At start-up it programs the PIO interrupt mask.
- It then waits for the PIO irq (or polls on a timer), reads and clears the edge-capture register, reads the live key levels, and presents one key event on a ready/valid stream to the password-checker logic.

Parameters:
- IRQ_MASK, 4'hF, value written to PIO address 2 during init.
- USE_IRQ, 1, 1 = service on irq; 0 = poll edge-capture every POLL_CYCLES.
- POLL_CYCLES, 50000, poll interval in clk cycles when USE_IRQ=0; legal range 4..2^20.

Ports:
- clk  in  1  system clock; the same clock as the PIO slave.
- reset_n  in  1  asynchronous, active-low reset.
- irq  in  1  PIO interrupt request (level).
- address  out  2  PIO word address.
- chipselect  out  1  PIO select.
- write_n  out  1  active-low write strobe.
- writedata  out  32  write data.
- readdata  in  32  PIO read data; registered in the slave, valid one cycle after address.
- event_valid  out  1  key event available.
- event_ready  in  1  consumer accepts the event.
- event_keys  out  4  edge-capture bits, i.e. the keys pressed (falling edges).
- event_level  out  4  live key levels sampled after the capture.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - address=0, chipselect=0, write_n=1, writedata=0.
  - event_valid=0, event_keys=0, event_level=0, busy=1.
  - FSM in INIT, poll counter cleared.
- Bus timing: fixed read latency 1, no waitrequest.
  - The FSM drives address in cycle N and samples readdata at the end of cycle N+1.
  - Only bits [3:0] of readdata are used.
  - chipselect is asserted in address cycles and write cycles only.
- FSM states:
  - INIT: drive address=2, chipselect=1, write_n=0, writedata={28'b0,IRQ_MASK} for exactly 1 cycle. Next state IDLE.
  - IDLE: busy=0. Trigger condition:
    - USE_IRQ=1: irq sampled high.
    - USE_IRQ=0: poll counter reaches POLL_CYCLES-1. The counter then wraps to 0. It runs only in IDLE and holds its value elsewhere.
    - On trigger, go to CAP_A.
  - CAP_A: address=3, chipselect=1, write_n=1. Next state CAP_D.
  - CAP_D: latch cap=readdata[3:0].
    - cap==0 (spurious trigger): go to IDLE; no write, no event.
    - Otherwise go to CLR.
  - CLR: address=3, chipselect=1, write_n=0, writedata={28'b0,cap}. Next state LVL_A.
  - LVL_A: address=0, chipselect=1. Next state LVL_D.
  - LVL_D: latch event_level=readdata[3:0], event_keys=cap, assert event_valid. Next state EMIT.
  - EMIT: hold event_valid and the event data stable until event_ready=1. On the handshake cycle, deassert event_valid in the next cycle and go to IDLE.
- Latency: irq high in IDLE → event_valid high 5 cycles later (CAP_A, CAP_D, CLR, LVL_A, LVL_D).
- No new bus activity while an event is pending.
  - The PIO keeps accumulating edges and irq stays high.
  - Edges arriving while EMIT is stalled are merged into the next event, never dropped.
- Known loss window: the slave clears all capture bits on any write.
  - An edge first captured during CAP_D or CLR is lost.
  - This is accepted; key debounce intervals are much longer than 2 cycles.
- event_ready asserted in a cycle where event_valid=0 is ignored.
- irq is level-sensitive; one event is produced per service pass, not per irq edge.
- Reset asserted mid-transaction: all outputs return to reset values asynchronously. INIT is re-executed after release, so the mask is rewritten.

Decomposition:
- Shared package holds:
  - FSM state enum {INIT, IDLE, CAP_A, CAP_D, CLR, LVL_A, LVL_D, EMIT}.
  - PIO address constants: PIO_DATA=0, PIO_MASK=2, PIO_EDGE=3.
  - PIO data width constant 4.
- One natural sub-module: key_poll_timer. It is a free-running enable counter, used only when USE_IRQ=0.

Test Plan:
- Reset release with IRQ_MASK=4'hA → exactly one write cycle (address=2, write_n=0, writedata=32'h0000000A), then busy=0.
- Model PIO: key1 press (falling edge), level 4'b1101 → irq; event_valid after 5 cycles with event_keys=4'b0010, event_level=4'b1101; one write to address 3 observed.
- Hold event_ready=0 for 20 cycles and press key3 meanwhile → event_valid and data stable. After accept, a second event with event_keys=4'b1000.
- Force irq high while edge-capture reads 0 → exactly CAP_A/CAP_D read, no write, no event, return to IDLE.
- USE_IRQ=0, POLL_CYCLES=8, no irq → an address=3 read every 8 IDLE cycles. With key0 captured, event_keys=4'b0001.
- Assert reset_n=0 during CLR → chipselect=0 and write_n=1 immediately. After release, INIT mask write repeats.

Source files
------------

// File: rtl/key_pio_service_master_pkg.sv
// Shared types and constants for the hardware key PIO service master.
// Register map and FSM encoding are common to the top and the bench.
package key_pio_service_master_pkg;

  localparam int unsigned PioWidth = 4;

  localparam logic [1:0] PioData = 2'd0;
  localparam logic [1:0] PioMask = 2'd2;
  localparam logic [1:0] PioEdge = 2'd3;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StCapA,
    StCapD,
    StClr,
    StLvlA,
    StLvlD,
    StEmit
  } state_e;

  function automatic logic [31:0] pio_word(input logic [PioWidth-1:0] v);
    return {{(32 - PioWidth){1'b0}}, v};
  endfunction

endpackage

// File: rtl/key_pio_service_master_if.sv
// Avalon-MM PIO bus plus the key event ready/valid stream.
// The master modport is the service FSM side; slave is the PIO/consumer side.
interface key_pio_service_master_if;
  import key_pio_service_master_pkg::*;

  logic                irq;
  logic [1:0]          address;
  logic                chipselect;
  logic                write_n;
  logic [31:0]         writedata;
  logic [31:0]         readdata;
  logic                event_valid;
  logic                event_ready;
  logic [PioWidth-1:0] event_keys;
  logic [PioWidth-1:0] event_level;
  logic                busy;

  modport master (
    input  irq, readdata, event_ready,
    output address, chipselect, write_n, writedata,
    output event_valid, event_keys, event_level, busy
  );

  modport slave (
    output irq, readdata, event_ready,
    input  address, chipselect, write_n, writedata,
    input  event_valid, event_keys, event_level, busy
  );

endinterface

// File: rtl/key_pio_service_master_poll_timer.sv
// Enable-gated poll counter: ticks once every PollCycles enabled cycles and
// holds its count while disabled.
module key_poll_timer #(
  parameter int unsigned PollCycles = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (PollCycles > 2) ? $clog2(PollCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PollCycles - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    tick_o = en_i && (cnt_q == CntMax);
    cnt_d  = cnt_q;
    if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_pio_service_master.sv
// Hardware service loop for the edge-capturing key PIO: programs the mask,
// then reads/clears edge capture and emits one key event per service pass.
module key_pio_service_master
  import key_pio_service_master_pkg::*;
#(
  parameter logic [3:0]  IRQ_MASK    = 4'hF,
  parameter bit          USE_IRQ     = 1'b1,
  parameter int unsigned POLL_CYCLES = 50000
) (
  input logic                       clk,
  input logic                       reset_n,
  key_pio_service_master_if.master  bus
);

  state_e              state_d, state_q;
  logic [1:0]          address_d, address_q;
  logic                chipselect_d, chipselect_q;
  logic                write_n_d, write_n_q;
  logic [31:0]         writedata_d, writedata_q;
  logic [PioWidth-1:0] cap_d, cap_q;
  logic                event_valid_d, event_valid_q;
  logic [PioWidth-1:0] event_keys_d, event_keys_q;
  logic [PioWidth-1:0] event_level_d, event_level_q;
  logic                busy_d, busy_q;

  logic                poll_tick;
  logic                trigger;
  logic [PioWidth-1:0] rd_bits;
  logic                unused_readdata;

  assign rd_bits         = bus.readdata[PioWidth-1:0];
  assign unused_readdata = ^bus.readdata[31:PioWidth];

  key_poll_timer #(
    .PollCycles (POLL_CYCLES)
  ) u_poll_timer (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .en_i   (!USE_IRQ && (state_q == StIdle)),
    .tick_o (poll_tick)
  );

  assign trigger = USE_IRQ ? bus.irq : poll_tick;

  // Bus outputs are computed for the state being entered, so each registered
  // strobe lines up with the cycle spent in that state.
  always_comb begin
    state_d       = state_q;
    address_d     = PioData;
    chipselect_d  = 1'b0;
    write_n_d     = 1'b1;
    writedata_d   = writedata_q;
    cap_d         = cap_q;
    event_valid_d = event_valid_q;
    event_keys_d  = event_keys_q;
    event_level_d = event_level_q;

    unique case (state_q)
      StInit: begin
        // First cycle after reset has idle outputs; the mask write follows it.
        if (!chipselect_q) begin
          address_d    = PioMask;
          chipselect_d = 1'b1;
          write_n_d    = 1'b0;
          writedata_d  = pio_word(IRQ_MASK);
        end else begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (trigger) begin
          state_d      = StCapA;
          address_d    = PioEdge;
          chipselect_d = 1'b1;
        end
      end
      StCapA: state_d = StCapD;
      StCapD: begin
        cap_d = rd_bits;
        if (rd_bits == '0) begin
          state_d = StIdle;
        end else begin
          state_d      = StClr;
          address_d    = PioEdge;
          chipselect_d = 1'b1;
          write_n_d    = 1'b0;
          writedata_d  = pio_word(rd_bits);
        end
      end
      StClr: begin
        state_d      = StLvlA;
        address_d    = PioData;
        chipselect_d = 1'b1;
      end
      StLvlA: state_d = StLvlD;
      StLvlD: begin
        event_level_d = rd_bits;
        event_keys_d  = cap_q;
        event_valid_d = 1'b1;
        state_d       = StEmit;
      end
      StEmit: begin
        if (bus.event_ready) begin
          event_valid_d = 1'b0;
          state_d       = StIdle;
        end
      end
      default: state_d = StInit;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StInit;
      address_q     <= PioData;
      chipselect_q  <= 1'b0;
      write_n_q     <= 1'b1;
      writedata_q   <= '0;
      cap_q         <= '0;
      event_valid_q <= 1'b0;
      event_keys_q  <= '0;
      event_level_q <= '0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      chipselect_q  <= chipselect_d;
      write_n_q     <= write_n_d;
      writedata_q   <= writedata_d;
      cap_q         <= cap_d;
      event_valid_q <= event_valid_d;
      event_keys_q  <= event_keys_d;
      event_level_q <= event_level_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.address     = address_q;
  assign bus.chipselect  = chipselect_q;
  assign bus.write_n     = write_n_q;
  assign bus.writedata   = writedata_q;
  assign bus.event_valid = event_valid_q;
  assign bus.event_keys  = event_keys_q;
  assign bus.event_level = event_level_q;
  assign bus.busy        = busy_q;

endmodule
